// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped seven-segment scan controller: hex or decimal display of a 32-bit value,
// with a sequential double-dabble converter, per-digit blanking and decimal overflow flag.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  digcs,
  input  logic                  digwrite,
  input  logic [1:0]            digaddr,
  input  logic [15:0]           write_data,
  output logic [NUM_DIGITS-1:0] DIG,
  output logic [7:0]            Y,
  output logic                  busy,
  output logic                  ovf
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PREW = $clog2(SCAN_DIV);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_DIGITS - 1);
  localparam logic [PREW-1:0] LAST_PRE = PREW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} convState_e;

  logic                  wrEn;
  logic                  loadEvt;
  logic [31:0]           value_q, value_d;
  logic                  decMode_q, decMode_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [DW-1:0]         disp_q;
  logic                  hexLoad_q;
  convState_e            state_q;
  logic [31:0]           bin_q;
  logic [39:0]           bcd_q;
  logic [39:0]           bcdAdj;
  logic [4:0]            cnt_q;
  logic                  busy_q;
  logic                  ovf_q;
  logic [PREW-1:0]       pre_q;
  logic [IDXW-1:0]       idx_q;
  logic [NUM_DIGITS-1:0] DIG_q;
  logic [7:0]            Y_q;

  function automatic logic [7:0] segOf(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Register-file decode; the converter latches the post-write value and mode.
  always_comb begin
    wrEn      = digcs & digwrite;
    loadEvt   = wrEn & (digaddr != 2'd3);
    value_d   = value_q;
    decMode_d = decMode_q;
    mask_d    = mask_q;
    if (wrEn) begin
      case (digaddr)
        2'd0: value_d[15:0]  = write_data;
        2'd1: value_d[31:16] = write_data;
        2'd2: begin
          decMode_d = write_data[0];
          mask_d    = write_data[8 +: NUM_DIGITS];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bcdAdj = '0;
    for (int i = 0; i < 10; i++) begin
      bcdAdj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= '0;
      decMode_q <= 1'b0;
      mask_q    <= '1;
    end else begin
      value_q   <= value_d;
      decMode_q <= decMode_d;
      mask_q    <= mask_d;
    end
  end

  // A new write always wins over an in-flight conversion, so restarts discard old work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q    <= '0;
      hexLoad_q <= 1'b0;
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      hexLoad_q <= 1'b0;
      if (hexLoad_q) disp_q <= value_q[DW-1:0];
      if (loadEvt && !decMode_d) begin
        hexLoad_q <= 1'b1;
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        ovf_q     <= 1'b0;
      end else if (loadEvt) begin
        bin_q   <= value_d;
        bcd_q   <= '0;
        cnt_q   <= '0;
        state_q <= SHIFT;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          SHIFT: begin
            bcd_q <= {bcdAdj[38:0], bin_q[31]};
            bin_q <= {bin_q[30:0], 1'b0};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= DONE;
          end
          DONE: begin
            disp_q  <= bcd_q[DW-1:0];
            ovf_q   <= |bcd_q[39:DW];
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
      DIG_q <= '1;
      Y_q   <= 8'hFF;
    end else begin
      if (pre_q == LAST_PRE) begin
        pre_q <= '0;
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      DIG_q <= mask_q[idx_q] ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      Y_q   <= segOf(disp_q[{idx_q, 2'b00} +: 4]);
    end
  end

  assign DIG  = DIG_q;
  assign Y    = Y_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (NUM_DIGITS=8, SCAN_DIV=4) with an independent scan-phase model.
module tb_seg7_scan_ctrl;

  localparam int N  = 8;
  localparam int SD = 4;

  logic        clk;
  logic        rst_n;
  logic        digcs;
  logic        digwrite;
  logic [1:0]  digaddr;
  logic [15:0] write_data;
  logic [7:0]  DIG;
  logic [7:0]  Y;
  logic        busy;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int cyc;

  logic [7:0] segTab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .digcs(digcs), .digwrite(digwrite), .digaddr(digaddr),
    .write_data(write_data), .DIG(DIG), .Y(Y), .busy(busy), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; output sampled after edge k shows digit ((k-1)/SD)%N.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  function automatic logic [7:0] expDig(input logic [7:0] m);
    int d;
    d = ((cyc - 1) / SD) % N;
    return m[d] ? ~(8'b1 << d) : 8'hFF;
  endfunction

  function automatic logic [7:0] expY(input logic [31:0] dsp);
    int d;
    d = ((cyc - 1) / SD) % N;
    return segTab[dsp[4*d +: 4]];
  endfunction

  task automatic writeReg(input logic [1:0] a, input logic [15:0] d, input logic cs, input logic we);
    @(negedge clk);
    digcs = cs; digwrite = we; digaddr = a; write_data = d;
    @(negedge clk);
    digcs = 1'b0; digwrite = 1'b0;
  endtask

  task automatic waitBusy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    total++; if (DIG !== 8'hFF) begin bad++; $display("[TB] FAIL reset_dig got=%h want=ff", DIG); end
    total++; if (Y !== 8'hFF) begin bad++; $display("[TB] FAIL reset_y got=%h want=ff", Y); end
    total++; if (busy !== 1'b0 || ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags busy=%b ovf=%b want 0 0", busy, ovf); end
    @(negedge clk) rst_n = 1'b1;
    writeReg(2'd2, 16'hFF01, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_busy got=%b want=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (DIG !== 8'hFF) begin bad++; $display("[TB] FAIL async_reset_dig got=%h want=ff", DIG); end
    total++; if (Y !== 8'hFF) begin bad++; $display("[TB] FAIL async_reset_y got=%h want=ff", Y); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_busy got=%b want=0", busy); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_hex();
    writeReg(2'd1, 16'h89AB, 1'b1, 1'b1);
    writeReg(2'd0, 16'hCDEF, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL hex_busy got=%b want=0", busy); end
    for (int i = 0; i < N * SD; i++) begin
      @(negedge clk);
      total++; if (DIG !== expDig(8'hFF)) begin bad++; $display("[TB] FAIL hex_dig cyc=%0d got=%h want=%h", cyc, DIG, expDig(8'hFF)); end
      total++; if (Y !== expY(32'h89ABCDEF)) begin bad++; $display("[TB] FAIL hex_y cyc=%0d got=%h want=%h", cyc, Y, expY(32'h89ABCDEF)); end
    end
  endtask

  task automatic test_no_write();
    writeReg(2'd0, 16'h1234, 1'b0, 1'b1);
    writeReg(2'd1, 16'h5678, 1'b1, 1'b0);
    writeReg(2'd2, 16'h0001, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL nowrite_busy got=%b want=0", busy); end
    for (int i = 0; i < N * SD; i++) begin
      @(negedge clk);
      total++; if (DIG !== expDig(8'hFF)) begin bad++; $display("[TB] FAIL nowrite_dig cyc=%0d got=%h want=%h", cyc, DIG, expDig(8'hFF)); end
      total++; if (Y !== expY(32'h89ABCDEF)) begin bad++; $display("[TB] FAIL nowrite_y cyc=%0d got=%h want=%h", cyc, Y, expY(32'h89ABCDEF)); end
    end
  endtask

  task automatic test_decimal();
    int n;
    writeReg(2'd2, 16'hFF01, 1'b1, 1'b1);
    writeReg(2'd1, 16'h00BC, 1'b1, 1'b1);
    writeReg(2'd0, 16'h614E, 1'b1, 1'b1);
    waitBusy(n);
    total++; if (n != 33) begin bad++; $display("[TB] FAIL dec_busy_len got=%0d want=33", n); end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL dec_ovf got=%b want=0", ovf); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N * SD; i++) begin
      @(negedge clk);
      total++; if (DIG !== expDig(8'hFF)) begin bad++; $display("[TB] FAIL dec_dig cyc=%0d got=%h want=%h", cyc, DIG, expDig(8'hFF)); end
      total++; if (Y !== expY(32'h12345678)) begin bad++; $display("[TB] FAIL dec_y cyc=%0d got=%h want=%h", cyc, Y, expY(32'h12345678)); end
    end
  endtask

  task automatic test_overflow();
    int n;
    writeReg(2'd1, 16'hFFFF, 1'b1, 1'b1);
    writeReg(2'd0, 16'hFFFF, 1'b1, 1'b1);
    waitBusy(n);
    total++; if (n != 33) begin bad++; $display("[TB] FAIL ovf_busy_len got=%0d want=33", n); end
    total++; if (ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", ovf); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N * SD; i++) begin
      @(negedge clk);
      total++; if (Y !== expY(32'h94967295)) begin bad++; $display("[TB] FAIL ovf_y cyc=%0d got=%h want=%h", cyc, Y, expY(32'h94967295)); end
    end
  endtask

  task automatic test_blank();
    writeReg(2'd2, 16'h0F00, 1'b1, 1'b1);
    writeReg(2'd0, 16'h3210, 1'b1, 1'b1);
    writeReg(2'd1, 16'h7654, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || ovf !== 1'b0) begin bad++; $display("[TB] FAIL blank_flags busy=%b ovf=%b want 0 0", busy, ovf); end
    for (int i = 0; i < N * SD; i++) begin
      @(negedge clk);
      total++; if (DIG !== expDig(8'h0F)) begin bad++; $display("[TB] FAIL blank_dig cyc=%0d got=%h want=%h", cyc, DIG, expDig(8'h0F)); end
      total++; if (Y !== expY(32'h76543210)) begin bad++; $display("[TB] FAIL blank_y cyc=%0d got=%h want=%h", cyc, Y, expY(32'h76543210)); end
    end
  endtask

  task automatic test_restart();
    int n;
    writeReg(2'd2, 16'hFF01, 1'b1, 1'b1);
    writeReg(2'd1, 16'h0000, 1'b1, 1'b1);
    writeReg(2'd0, 16'h0001, 1'b1, 1'b1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy) n++;
      else if (i > 10) break;
      if (i == 9) begin
        digcs = 1'b1; digwrite = 1'b1; digaddr = 2'd0; write_data = 16'h0063;
      end
      if (i == 10) begin
        digcs = 1'b0; digwrite = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (n != 43) begin bad++; $display("[TB] FAIL restart_busy_len got=%0d want=43", n); end
    total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL restart_ovf got=%b want=0", ovf); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N * SD; i++) begin
      @(negedge clk);
      total++; if (Y !== expY(32'h00000099)) begin bad++; $display("[TB] FAIL restart_y cyc=%0d got=%h want=%h", cyc, Y, expY(32'h00000099)); end
    end
  endtask

  initial begin
    digcs = 1'b0; digwrite = 1'b0; digaddr = 2'd0; write_data = 16'h0000;
    test_reset();
    test_hex();
    test_no_write();
    test_decimal();
    test_overflow();
    test_blank();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised memory-mapped seven-segment scan controller that replaces the fixed-width tube driver on the CPU IO bus. It holds a 32-bit display value and a control word written by the CPU via `sw` to the digit chip-select. It drives NUM_DIGITS multiplexed digits in either hex mode or decimal mode; decimal mode uses an on-block sequential binary-to-BCD converter. It also supports per-digit blanking and reports a decimal overflow flag.

## Interface
- NUM_DIGITS, 8: digits driven, legal 1..8.
- SCAN_DIV, 100000: clk cycles per digit slot, legal ≥2.
- clk  in  1  system clock (same as cpu_clk).
- rst_n  in  1  reset; asynchronous, active-low.
- digcs  in  1  chip select from MemOrIO address decode.
- digwrite  in  1  IO write strobe.
- digaddr  in  2  register select; address[3:2] of the CPU access.
- write_data  in  16  write data.
- DIG  out  NUM_DIGITS  digit enables, active-low, registered.
- Y  out  8  segments, active-low, registered. Y[6:0]=gfedcba, Y[7]=dp (always 1).
- busy  out  1  decimal conversion in progress.
- ovf  out  1  last decimal result needs more than NUM_DIGITS digits.

## Operation
- Write accepted on a rising clk edge when digcs & digwrite. Decode:
  - 0 → value[15:0]
  - 1 → value[31:16]
  - 2 → ctrl: bit0 = dec_mode, bits[15:8] = digit enable mask (bit i enables digit i; bits ≥ NUM_DIGITS ignored)
  - 3 → ignored
- Display buffer disp (NUM_DIGITS×4 bits) is what gets scanned. disp never changes except as described below.
- Hex mode:
  - On the cycle after any accepted write, disp ← value[4·NUM_DIGITS-1:0].
  - Any running conversion is aborted, busy←0, ovf←0.
- Decimal mode: any accepted write (value or ctrl) starts the converter FSM.
  - IDLE: on write, latch value into shift register, clear BCD (40 bits), cnt←0 → SHIFT, busy←1.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left 1; cnt++. After the 32nd shift → DONE.
  - DONE: disp ← low 4·NUM_DIGITS BCD bits; ovf ← OR of higher BCD bits; busy←0 → IDLE.
  - A write in SHIFT or DONE restarts from the new value; the old result is discarded and busy stays 1.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - At the terminal count, idx advances, wrapping NUM_DIGITS-1→0.
  - Each cycle: DIG ← ~(1<<idx) if mask[idx], else all-ones. Y ← seg(disp nibble idx).
- Seg table (hex): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

## Timing
- Reset (async assert, sync release):
  - value=0, dec_mode=0, mask=all ones, disp=0, FSM IDLE, busy=0, ovf=0
  - prescaler=0, idx=0, DIG=all ones, Y=8'hFF
- Hex write at edge W: value at W, disp at W+1, DIG/Y reflect it at W+2 if idx selects that digit.
- Decimal write at edge W:
  - busy=1 after W
  - shifts on W+1..W+32
  - disp/ovf load and busy=0 at W+33
- Digit slot length is exactly SCAN_DIV cycles. Full refresh takes NUM_DIGITS·SCAN_DIV cycles.
- Mask change takes effect on DIG one cycle after the write; the scan phase is unaffected.
- Writes with digcs=0 or digwrite=0 have no effect.
- Mode change hex→dec starts a conversion.

## Test plan
- Reset: rst_n low mid-scan → DIG=8'hFF, Y=8'hFF, busy=0 immediately (asynchronous).
- Hex, SCAN_DIV=4, NUM_DIGITS=8: write addr1=16'h89AB, then addr0=16'hCDEF → over one 32-cycle frame, digit0 Y=8E, digit3 Y=C6, digit7 Y=80. Each DIG one-hot low for 4 cycles.
- Decimal: ctrl=16'hFF01, then value=12345678 → busy high exactly 33 cycles. Afterwards digit0 Y=80 ('8'), digit7 Y=F9 ('1'), ovf=0.
- Overflow: decimal mode, value=32'hFFFFFFFF (4294967295), NUM_DIGITS=8 → disp=BCD 94967295, ovf=1.
- Restart: decimal mode, write value=1; 10 cycles later write value=99 → busy continuous for 43 cycles total, final disp=...0099.
- Blank: ctrl=16'h0F00 (hex) → DIG bits 7..4 stay 1 during their slots, digits 0..3 still scan.
